// File: rtl/multicycle_sequencer_if.sv
// rtl/multicycle_sequencer_if.sv - control/handshake bundle between the sequencer and its datapath
// master = the sequencer (drives strobes/indicators), slave = datapath side (drives start/opcode/ALU status).
interface multicycle_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [5:0]       opcode;
  logic             alu_done;
  logic             alu_zero;
  logic             IF, ID, EX, MEM, WB, JU, BR;
  logic             ir_we;
  logic             mem_en;
  logic             mem_wen;
  logic             alu_en;
  logic             reg_we;
  logic             pc_we;
  logic [1:0]       pc_sel;
  logic [CNT_W-1:0] instr_count;
  logic             halted;
  logic             err;

  modport master (
    input  start, opcode, alu_done, alu_zero,
    output IF, ID, EX, MEM, WB, JU, BR, ir_we, mem_en, mem_wen, alu_en,
           reg_we, pc_we, pc_sel, instr_count, halted, err
  );

  modport slave (
    output start, opcode, alu_done, alu_zero,
    input  IF, ID, EX, MEM, WB, JU, BR, ir_we, mem_en, mem_wen, alu_en,
           reg_we, pc_we, pc_sel, instr_count, halted, err
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multicycle instruction sequencer with registered Moore outputs
// Optional EXEC watchdog enabled by defining EXEC_TIMEOUT_EN.
module multicycle_sequencer #(
  parameter int MEM_WAIT     = 2,
  parameter int CNT_W        = 16,
  parameter int EXEC_TIMEOUT = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  multicycle_sequencer_if.master bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEMACC, S_WRITEBACK, S_JUMP, S_BRANCH, S_HALT
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_HALT = 6'h3F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;

  state_t           state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic [5:0]       op_q, op_d;
  logic             taken_q, taken_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic [6:0]       ind_q, ind_d;
  logic             ir_we_q, ir_we_d, mem_en_q, mem_en_d, mem_wen_q, mem_wen_d;
  logic             alu_en_q, alu_en_d, reg_we_q, reg_we_d, pc_we_q, pc_we_d;
  logic [1:0]       pc_sel_q, pc_sel_d;
  logic             halted_q, halted_d;
`ifdef EXEC_TIMEOUT_EN
  localparam int             TMO_W    = $clog2(EXEC_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(EXEC_TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    op_d    = op_q;
    taken_d = taken_q;
    retire  = 1'b0;
`ifdef EXEC_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        wait_d = 4'd0;
        if (bus.start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (wait_q == WAIT_LAST) begin
          state_d = S_DECODE;
          wait_d  = 4'd0;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      S_DECODE: begin
        // IR is stable from here on; keep a private copy so later states
        // do not depend on the datapath holding opcode.
        op_d   = bus.opcode;
        wait_d = 4'd0;
`ifdef EXEC_TIMEOUT_EN
        tmo_d  = '0;
`endif
        if (bus.opcode == OP_J || bus.opcode == OP_JAL) state_d = S_JUMP;
        else if (bus.opcode == OP_HALT)                 state_d = S_HALT;
        else                                            state_d = S_EXEC;
      end
      S_EXEC: begin
        if (bus.alu_done) begin
          taken_d = (op_q == OP_BEQ && bus.alu_zero) || (op_q == OP_BNE && !bus.alu_zero);
          wait_d  = 4'd0;
          if (op_q == OP_LW || op_q == OP_SW)       state_d = S_MEMACC;
          else if (op_q == OP_BEQ || op_q == OP_BNE) state_d = S_BRANCH;
          else                                      state_d = S_WRITEBACK;
        end
`ifdef EXEC_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      S_MEMACC: begin
        if (wait_q == WAIT_LAST) begin
          wait_d = 4'd0;
          if (op_q == OP_LW) state_d = S_WRITEBACK;
          else               retire  = 1'b1;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      S_WRITEBACK, S_JUMP, S_BRANCH: retire = 1'b1;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    if (retire) begin
      state_d = bus.start ? S_FETCH : S_IDLE;
      wait_d  = 4'd0;
    end
  end

  // Outputs are decoded from the state being entered so they are registered
  // yet line up with the state they describe.
  always_comb begin
    ind_d     = {state_d == S_FETCH, state_d == S_DECODE, state_d == S_EXEC,
                 state_d == S_MEMACC, state_d == S_WRITEBACK, state_d == S_JUMP,
                 state_d == S_BRANCH};
    ir_we_d   = (state_d == S_FETCH) && (wait_d == WAIT_LAST);
    mem_en_d  = (state_d == S_FETCH) || (state_d == S_MEMACC);
    mem_wen_d = (state_d == S_MEMACC) && (op_d == OP_SW);
    alu_en_d  = (state_d == S_EXEC);
    reg_we_d  = (state_d == S_WRITEBACK);
    pc_we_d   = (state_d == S_WRITEBACK) || (state_d == S_JUMP) || (state_d == S_BRANCH) ||
                ((state_d == S_MEMACC) && (wait_d == WAIT_LAST) && (op_d == OP_SW));
    pc_sel_d  = (state_d == S_JUMP) ? 2'b10 :
                ((state_d == S_BRANCH) && taken_d) ? 2'b01 : 2'b00;
    halted_d  = (state_d == S_HALT);
    cnt_d     = cnt_q + CNT_W'(pc_we_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wait_q    <= 4'd0;
      op_q      <= 6'd0;
      taken_q   <= 1'b0;
      cnt_q     <= '0;
      ind_q     <= 7'd0;
      ir_we_q   <= 1'b0;
      mem_en_q  <= 1'b0;
      mem_wen_q <= 1'b0;
      alu_en_q  <= 1'b0;
      reg_we_q  <= 1'b0;
      pc_we_q   <= 1'b0;
      pc_sel_q  <= 2'b00;
      halted_q  <= 1'b0;
`ifdef EXEC_TIMEOUT_EN
      tmo_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      op_q      <= op_d;
      taken_q   <= taken_d;
      cnt_q     <= cnt_d;
      ind_q     <= ind_d;
      ir_we_q   <= ir_we_d;
      mem_en_q  <= mem_en_d;
      mem_wen_q <= mem_wen_d;
      alu_en_q  <= alu_en_d;
      reg_we_q  <= reg_we_d;
      pc_we_q   <= pc_we_d;
      pc_sel_q  <= pc_sel_d;
      halted_q  <= halted_d;
`ifdef EXEC_TIMEOUT_EN
      tmo_q     <= tmo_d;
      err_q     <= err_d;
`endif
    end
  end

  assign {bus.IF, bus.ID, bus.EX, bus.MEM, bus.WB, bus.JU, bus.BR} = ind_q;
  assign bus.ir_we       = ir_we_q;
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_wen     = mem_wen_q;
  assign bus.alu_en      = alu_en_q;
  assign bus.reg_we      = reg_we_q;
  assign bus.pc_we       = pc_we_q;
  assign bus.pc_sel      = pc_sel_q;
  assign bus.instr_count = cnt_q;
  assign bus.halted      = halted_q;
`ifdef EXEC_TIMEOUT_EN
  assign bus.err         = err_q;
`else
  assign bus.err         = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - randomized bench with per-instruction trace model for multicycle_sequencer
// Expected outputs are built per instruction from the stage rules, then compared every cycle.
module tb_multicycle_sequencer;
  localparam int MEM_WAIT = 2;
  localparam int CNT_W    = 3;
`ifdef EXEC_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 64;
`endif

  // {IF,ID,EX,MEM,WB,JU,BR,ir_we,mem_en,mem_wen,alu_en,reg_we,pc_we,pc_sel[1:0],halted,err}
  localparam logic [16:0] V_IF   = 17'h10000, V_ID  = 17'h08000, V_EX   = 17'h04000;
  localparam logic [16:0] V_MEM  = 17'h02000, V_WB  = 17'h01000, V_JU   = 17'h00800;
  localparam logic [16:0] V_BR   = 17'h00400, V_IRWE = 17'h00200, V_MEN = 17'h00100;
  localparam logic [16:0] V_MWEN = 17'h00080, V_AEN = 17'h00040, V_RWE  = 17'h00020;
  localparam logic [16:0] V_PCWE = 17'h00010, V_PSJ = 17'h00008, V_PSB  = 17'h00004;
  localparam logic [16:0] V_HALT = 17'h00002, V_ERR = 17'h00001;

  typedef struct {
    bit               st;
    bit               dn;
    bit               zr;
    logic [5:0]       op;
    logic [16:0]      v;
    logic [CNT_W-1:0] c;
    bit               lit;
    logic [16:0]      lv;
    logic [CNT_W-1:0] lc;
    int               id;
  } cyc_t;

  logic clk;
  logic rst_n;
  multicycle_sequencer_if #(.CNT_W(CNT_W)) bus();

  multicycle_sequencer #(
    .MEM_WAIT(MEM_WAIT), .CNT_W(CNT_W), .EXEC_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cyc_t plan[$];
  cyc_t exp_q[$];
  int   m_cnt;
  int   step_id;
  int   n_vec;
  int   n_fail;

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] ro();
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic add(input logic [16:0] v, input bit st, input bit dn, input bit zr,
                     input logic [5:0] op);
    cyc_t r;
    r.st = st; r.dn = dn; r.zr = zr; r.op = op; r.v = v;
    r.c = CNT_W'(m_cnt); r.lit = 1'b0; r.lv = '0; r.lc = '0; r.id = step_id;
    step_id++;
    plan.push_back(r);
  endtask

  task automatic retire_add(input logic [16:0] v, input bit st, input logic [5:0] op);
    m_cnt = (m_cnt + 1) % (1 << CNT_W);
    add(v | V_PCWE, st, rb(), rb(), op);
  endtask

  task automatic pin(input logic [16:0] v, input logic [CNT_W-1:0] c);
    cyc_t r;
    r = plan.pop_back();
    r.lit = 1'b1; r.lv = v; r.lc = c;
    plan.push_back(r);
  endtask

  task automatic idle(input int n_wait);
    for (int i = 0; i < n_wait; i++) add(17'h0, 1'b0, rb(), rb(), ro());
    add(17'h0, 1'b1, rb(), rb(), ro());
  endtask

  // One instruction from FETCH entry through its retire cycle (or into HALT).
  task automatic gen_instr(input logic [5:0] op, input int d, input bit zr, input bit st_end);
    bit taken;
    for (int i = 0; i <= MEM_WAIT; i++)
      add(V_IF | V_MEN | ((i == MEM_WAIT) ? V_IRWE : 17'h0), rb(), rb(), rb(), ro());
    add(V_ID, rb(), rb(), rb(), op);
    if (op == 6'h02 || op == 6'h03) begin
      retire_add(V_JU | V_PSJ, st_end, op);
      return;
    end
    if (op == 6'h3F) begin
      for (int k = 0; k < 6; k++) add(V_HALT, rb(), rb(), rb(), ro());
      return;
    end
`ifdef EXEC_TIMEOUT_EN
    if (d >= TMO) begin
      for (int k = 0; k < TMO; k++) add(V_EX | V_AEN, rb(), 1'b0, rb(), op);
      for (int k = 0; k < 4; k++) add(V_HALT | V_ERR, rb(), rb(), rb(), ro());
      return;
    end
`endif
    for (int k = 0; k < d; k++) add(V_EX | V_AEN, rb(), 1'b0, rb(), op);
    add(V_EX | V_AEN, rb(), 1'b1, zr, op);
    taken = (op == 6'h04 && zr) || (op == 6'h05 && !zr);
    if (op == 6'h23) begin
      for (int i = 0; i <= MEM_WAIT; i++) add(V_MEM | V_MEN, rb(), rb(), rb(), op);
      retire_add(V_WB | V_RWE, st_end, op);
    end else if (op == 6'h2B) begin
      for (int i = 0; i < MEM_WAIT; i++) add(V_MEM | V_MEN | V_MWEN, rb(), rb(), rb(), op);
      retire_add(V_MEM | V_MEN | V_MWEN, st_end, op);
    end else if (op == 6'h04 || op == 6'h05) begin
      retire_add(V_BR | (taken ? V_PSB : 17'h0), st_end, op);
    end else begin
      retire_add(V_WB | V_RWE, st_end, op);
    end
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] o;
    case ($urandom_range(0, 7))
      0: o = 6'h00;
      1: o = 6'h23;
      2: o = 6'h2B;
      3: o = 6'h04;
      4: o = 6'h05;
      5: o = 6'h02;
      6: o = 6'h03;
      default: begin
        o = ro();
        if (o inside {6'h02, 6'h03, 6'h3F, 6'h23, 6'h2B, 6'h04, 6'h05}) o = 6'h20;
      end
    endcase
    return o;
  endfunction

  task automatic run_plan();
    cyc_t r;
    while (plan.size() != 0) begin
      r = plan.pop_front();
      bus.start    = r.st;
      bus.opcode   = r.op;
      bus.alu_done = r.dn;
      bus.alu_zero = r.zr;
      exp_q.push_back(r);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rst_chk();
    cyc_t r;
    r.st = 1'b0; r.dn = 1'b0; r.zr = 1'b0; r.op = 6'h0; r.v = 17'h0; r.c = '0;
    r.lit = 1'b0; r.lv = '0; r.lc = '0; r.id = -1;
    exp_q.push_back(r);
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    rst_chk();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_cnt = 0;
  endtask

  logic [16:0] act;
  cyc_t        e;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      act = {bus.IF, bus.ID, bus.EX, bus.MEM, bus.WB, bus.JU, bus.BR, bus.ir_we, bus.mem_en,
             bus.mem_wen, bus.alu_en, bus.reg_we, bus.pc_we, bus.pc_sel, bus.halted, bus.err};
      n_vec++;
      if (act !== e.v || bus.instr_count !== e.c) begin
        n_fail++;
        $display("FAIL step %0d outputs: got %h cnt %0d, want %h cnt %0d",
                 e.id, act, bus.instr_count, e.v, e.c);
      end
      if (e.lit) begin
        n_vec++;
        if (act !== e.lv || bus.instr_count !== e.lc) begin
          n_fail++;
          $display("FAIL step %0d pinned: got %h cnt %0d, want %h cnt %0d",
                   e.id, act, bus.instr_count, e.lv, e.lc);
        end
      end
    end
  end

  initial begin
    n_vec = 0; n_fail = 0; m_cnt = 0; step_id = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.opcode = 6'h0; bus.alu_done = 1'b0; bus.alu_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_chk();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed: R-type, lw, sw, beq taken, bne not taken, jump
    idle(1);
    gen_instr(6'h00, 0, 1'b0, 1'b0); pin(17'h01030, 3'd1);
    idle(0);
    gen_instr(6'h23, 1, 1'b0, 1'b1); pin(17'h01030, 3'd2);
    gen_instr(6'h2B, 0, 1'b0, 1'b0); pin(17'h02190, 3'd3);
    idle(0);
    gen_instr(6'h04, 0, 1'b1, 1'b1); pin(17'h00414, 3'd4);
    gen_instr(6'h05, 2, 1'b1, 1'b1); pin(17'h00410, 3'd5);
    gen_instr(6'h02, 0, 1'b0, 1'b0); pin(17'h00818, 3'd6);
    run_plan();

    // Random instruction stream, counter wraps several times
    idle(0);
    for (int n = 0; n < 40; n++) begin
      bit se;
      se = rb();
      gen_instr(pick_op(), int'($urandom_range(0, 3)), rb(), se);
      if (!se) idle(int'($urandom_range(0, 2)));
      run_plan();
    end
    gen_instr(6'h00, 0, 1'b0, 1'b0);
    add(17'h0, 1'b0, rb(), rb(), ro());
    run_plan();

    // Reset in the middle of a load's memory access
    idle(0);
    gen_instr(6'h23, 0, 1'b0, 1'b0);
    for (int i = 0; i <= MEM_WAIT; i++) void'(plan.pop_back());
    run_plan();
    rst_n = 1'b0;
    rst_chk();
    @(posedge clk);
    #1;
    rst_pulse();

    // HALT holds against start toggling until reset
    idle(1);
    gen_instr(6'h00, 1, 1'b0, 1'b1);
    gen_instr(6'h3F, 0, 1'b0, 1'b0); pin(17'h00002, 3'd1);
    run_plan();
    rst_pulse();

`ifdef EXEC_TIMEOUT_EN
    idle(0);
    gen_instr(6'h00, TMO + 3, 1'b0, 1'b0); pin(17'h00003, 3'd0);
    run_plan();
    rst_pulse();
`endif

    idle(0);
    gen_instr(6'h00, 0, 1'b0, 1'b0); pin(17'h01030, 3'd1);
    add(17'h0, 1'b0, rb(), rb(), ro());
    run_plan();
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
